// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: datapath widths, opcode and
// ALU-function encodings, flag bit positions and pipeline payload structs.
package alu_pkg;

    localparam int unsigned WIDTH  = 24;
    localparam int unsigned TAGW   = 4;
    localparam int unsigned OPW    = 3;
    localparam int unsigned ALUOPW = 2;
    localparam int unsigned FLAGW  = 4;

    // Instruction opcodes
    localparam logic [OPW-1:0] OP_AND  = 3'd0;
    localparam logic [OPW-1:0] OP_OR   = 3'd1;
    localparam logic [OPW-1:0] OP_ADD  = 3'd2;
    localparam logic [OPW-1:0] OP_SUB  = 3'd3;
    localparam logic [OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [OPW-1:0] OP_NAND = 3'd5;
    localparam logic [OPW-1:0] OP_SLT  = 3'd6;
    localparam logic [OPW-1:0] OP_CMP  = 3'd7;

    // ALU function select
    localparam logic [ALUOPW-1:0] ALUOP_AND = 2'b00;
    localparam logic [ALUOPW-1:0] ALUOP_OR  = 2'b01;
    localparam logic [ALUOPW-1:0] ALUOP_ADD = 2'b10;

    // Bit positions inside the {Z,N,C,V} flags vector
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Issue-stage (E1) payload
    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAGW-1:0]  tag;
    } issue_t;

    // Writeback-stage (E2) payload
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAGW-1:0]  tag;
        logic             wben;
    } wb_t;

    // Decoded control for one opcode
    typedef struct packed {
        logic [ALUOPW-1:0] alu_op;
        logic              a_invert;
        logic              b_negate;
        logic              is_arith;
        logic              wben;
        logic              is_slt;
    } dec_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Instruction-in and writeback-out handshake bus of the ALU execute stage.
//   in_*  : upstream instruction (valid/ready, opcode, operands, tag)
//   out_* : writeback entry (valid/ready, data, tag, register-file write enable)
// master = the environment around the stage, slave = the stage itself.
interface alu_exec_stage_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAGW-1:0]  in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAGW-1:0]  out_tag;
    logic             out_wben;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        input  in_ready,
        input  out_valid, out_data, out_tag, out_wben,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        output in_ready,
        output out_valid, out_data, out_tag, out_wben,
        input  out_ready
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps an instruction opcode onto the ALU
// function select, operand inversion controls and writeback attributes.
//   op  : instruction opcode
//   dec : {alu_op, a_invert, b_negate, is_arith, wben, is_slt}
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OPW-1:0] op,
    output dec_t           dec
);

    always_comb begin
        dec          = '0;
        dec.wben     = 1'b1;
        case (op)
            OP_AND: dec.alu_op = ALUOP_AND;
            OP_OR:  dec.alu_op = ALUOP_OR;
            OP_ADD: begin
                dec.alu_op   = ALUOP_ADD;
                dec.is_arith = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op   = ALUOP_ADD;
                dec.b_negate = 1'b1;
                dec.is_arith = 1'b1;
            end
            // NOR/NAND via De Morgan on inverted operands
            OP_NOR: begin
                dec.alu_op   = ALUOP_AND;
                dec.a_invert = 1'b1;
                dec.b_negate = 1'b1;
            end
            OP_NAND: begin
                dec.alu_op   = ALUOP_OR;
                dec.a_invert = 1'b1;
                dec.b_negate = 1'b1;
            end
            OP_SLT: begin
                dec.alu_op   = ALUOP_ADD;
                dec.b_negate = 1'b1;
                dec.is_arith = 1'b1;
                dec.is_slt   = 1'b1;
            end
            OP_CMP: begin
                dec.alu_op   = ALUOP_ADD;
                dec.b_negate = 1'b1;
                dec.is_arith = 1'b1;
                dec.wben     = 1'b0;
            end
            default: dec.alu_op = ALUOP_AND;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage around an external 24-bit combinational ALU.
// Two registered stages: E1 (issue) drives the ALU, E2 (writeback) holds the
// result for the consumer. Also keeps architectural flags and sticky overflow.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus             : instruction-in / writeback-out handshakes (slave side)
//   alu_a/b/op, alu_a_invert, alu_b_negate : ALU controls, combinational from E1
//   alu_result/zero/overflow/carry_out     : ALU results
//   flags           : {Z,N,C,V}, updated on each E1->E2 transfer
//   sticky_v        : set on any signed overflow, cleared only by reset
module alu_exec_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_stage_if.slave   bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic              alu_a_invert,
    output logic              alu_b_negate,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    output logic [FLAGW-1:0]  flags,
    output logic              sticky_v
);

    issue_t           e1_q;
    logic             e1_valid_q;
    wb_t              e2_q;
    logic             e2_valid_q;
    logic [FLAGW-1:0] flags_q;
    logic             sticky_q;

    dec_t             dec;
    logic             e2_free_c;
    logic             xfer_c;
    logic             in_ready_c;
    logic             accept_c;
    wb_t              wb_c;
    logic [FLAGW-1:0] flags_c;
    logic             sticky_c;

    alu_op_decode u_decode (
        .op  (e1_q.op),
        .dec (dec)
    );

    // Handshake: E2 frees when empty or draining; E1 accepts when it can move on
    assign e2_free_c  = ~e2_valid_q | bus.out_ready;
    assign xfer_c     = e1_valid_q & e2_free_c;
    assign in_ready_c = ~e1_valid_q | e2_free_c;
    assign accept_c   = bus.in_valid & in_ready_c;

    // ALU drive, quiet when E1 is empty
    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;
        alu_a_invert = 1'b0;
        alu_b_negate = 1'b0;
        if (e1_valid_q) begin
            alu_a        = e1_q.a;
            alu_b        = e1_q.b;
            alu_op       = dec.alu_op;
            alu_a_invert = dec.a_invert;
            alu_b_negate = dec.b_negate;
        end
    end

    // Writeback payload and flag values captured on transfer
    always_comb begin
        wb_c      = '0;
        flags_c   = '0;
        wb_c.tag  = e1_q.tag;
        wb_c.wben = dec.wben;
        // SLT: sign of (a-b) corrected by overflow gives the signed less-than
        if (dec.is_slt) begin
            wb_c.data = WIDTH'(alu_result[WIDTH-1] ^ alu_overflow);
        end else begin
            wb_c.data = alu_result;
        end
        flags_c[FLAG_Z] = alu_zero;
        flags_c[FLAG_N] = alu_result[WIDTH-1];
        if (dec.is_arith) begin
            flags_c[FLAG_C] = alu_carry_out;
            flags_c[FLAG_V] = alu_overflow;
        end
        sticky_c = sticky_q | (dec.is_arith & alu_overflow);
    end

    // Pipeline, flag and sticky registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e1_valid_q <= 1'b0;
            e1_q       <= '0;
            e2_valid_q <= 1'b0;
            e2_q       <= '0;
            flags_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            e1_valid_q <= accept_c | (e1_valid_q & ~xfer_c);
            if (accept_c) begin
                e1_q.op  <= bus.in_op;
                e1_q.a   <= bus.in_a;
                e1_q.b   <= bus.in_b;
                e1_q.tag <= bus.in_tag;
            end
            e2_valid_q <= xfer_c | (e2_valid_q & ~bus.out_ready);
            if (xfer_c) begin
                e2_q     <= wb_c;
                flags_q  <= flags_c;
                sticky_q <= sticky_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = e2_valid_q;
    assign bus.out_data  = e2_q.data;
    assign bus.out_tag   = e2_q.tag;
    assign bus.out_wben  = e2_q.wben;
    assign flags         = flags_q;
    assign sticky_v      = sticky_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU attached to the ALU ports,
// directed cases followed by randomized traffic, scoreboard of expected
// writebacks computed from opcode semantics with plain integer arithmetic.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_exec_stage_if bus ();

    logic [23:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_op;
    logic        alu_a_invert, alu_b_negate;
    logic        alu_zero, alu_overflow, alu_carry_out;
    logic [3:0]  flags;
    logic        sticky_v;

    alu_exec_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_a_invert  (alu_a_invert),
        .alu_b_negate  (alu_b_negate),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out),
        .flags         (flags),
        .sticky_v      (sticky_v)
    );

    // Behavioural 24-bit ALU: optional operand inversion, carry-in = BNegate
    logic [23:0] aa, bb;
    logic [24:0] sum;
    always_comb begin
        aa  = alu_a_invert ? ~alu_a : alu_a;
        bb  = alu_b_negate ? ~alu_b : alu_b;
        sum = {1'b0, aa} + {1'b0, bb} + 25'(alu_b_negate);
        case (alu_op)
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            default: alu_result = sum[23:0];
        endcase
        alu_zero      = (alu_result == 24'd0);
        alu_carry_out = sum[24];
        alu_overflow  = (aa[23] == bb[23]) && (sum[23] != aa[23]);
    end

    typedef struct {
        logic [23:0] data;
        logic [3:0]  tag;
        logic        wben;
        logic [3:0]  flg;
        logic        sticky;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    bit          sticky_m = 1'b0;
    bit          hold_pend = 1'b0;
    logic [23:0] hold_data;
    logic [3:0]  hold_tag;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference semantics of one instruction
    function automatic exp_t model(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b);
        exp_t        e;
        int          sa, sbv, sres;
        longint      ua, ub;
        logic [23:0] r;
        logic        c, v;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = longint'(a);
        ub  = longint'(b);
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_ADD: begin
                r    = 24'(ua + ub);
                c    = (ua + ub) >= 64'sd16777216;
                sres = sa + sbv;
                v    = (sres > 8388607) || (sres < -8388608);
            end
            default: begin
                r    = 24'(ua - ub);
                c    = (ua >= ub);
                sres = sa - sbv;
                v    = (sres > 8388607) || (sres < -8388608);
            end
        endcase
        e.flg  = {r == 24'd0, r[23], c, v};
        e.data = (op == OP_SLT) ? 24'(sa < sbv) : r;
        e.wben = (op != OP_CMP);
        e.tag  = '0;
        e.sticky = 1'b0;
        return e;
    endfunction

    function automatic logic [23:0] rnd_operand();
        case ($urandom % 6)
            0:       return 24'h000000;
            1:       return 24'h7FFFFF;
            2:       return 24'h800000;
            3:       return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    // One clock: drive inputs, check at negedge, update scoreboard, advance
    task automatic step(input bit v, input logic [2:0] op, input logic [23:0] a,
                        input logic [23:0] b, input logic [3:0] tag, input bit ordy,
                        output bit acc);
        exp_t e;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        @(negedge clk);
        check_eq("in_ready", 32'(bus.in_ready), 32'((sb.size() < 2) || ordy));
        if (sb.size() == 0) check_eq("out_valid_idle", 32'(bus.out_valid), 32'(0));
        if (hold_pend) begin
            check_eq("hold_valid", 32'(bus.out_valid), 32'(1));
            check_eq("hold_data", 32'(bus.out_data), 32'(hold_data));
            check_eq("hold_tag", 32'(bus.out_tag), 32'(hold_tag));
        end
        if (bus.out_valid && ordy && sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("out_data", 32'(bus.out_data), 32'(e.data));
            check_eq("out_tag", 32'(bus.out_tag), 32'(e.tag));
            check_eq("out_wben", 32'(bus.out_wben), 32'(e.wben));
            check_eq("flags", 32'(flags), 32'(e.flg));
            check_eq("sticky_v", 32'(sticky_v), 32'(e.sticky));
        end
        hold_pend = bus.out_valid && !ordy;
        hold_data = bus.out_data;
        hold_tag  = bus.out_tag;
        acc = v && bus.in_ready;
        if (acc) begin
            e        = model(op, a, b);
            e.tag    = tag;
            sticky_m = sticky_m | e.flg[0];
            e.sticky = sticky_m;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [3:0] tag);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, op, a, b, tag, 1'b1, acc);
            n++;
        end
        check_eq("issue_accept", 32'(acc), 32'(1));
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            step(1'b0, OP_AND, '0, '0, '0, 1'b1, acc);
            n++;
        end
        check_eq("drain_empty", 32'(sb.size()), 32'(0));
        repeat (2) step(1'b0, OP_AND, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check_eq("rst_flags", 32'(flags), 32'(0));
        check_eq("rst_sticky", 32'(sticky_v), 32'(0));
        check_eq("rst_out_data", 32'(bus.out_data), 32'(0));
        check_eq("rst_out_tag", 32'(bus.out_tag), 32'(0));
        check_eq("rst_out_wben", 32'(bus.out_wben), 32'(0));
        check_eq("rst_alu_a", 32'(alu_a), 32'(0));
    endtask

    initial begin
        bit acc;
        bit have_pend;
        logic [2:0]  p_op;
        logic [23:0] p_a, p_b;
        logic [3:0]  p_tag;
        int idx, c;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed opcode cases
        issue(OP_ADD,  24'h000001, 24'h000002, 4'd1);
        issue(OP_SUB,  24'h7FFFFF, 24'hFFFFFF, 4'd2);
        issue(OP_AND,  24'h123456, 24'hF0F0F0, 4'd3);
        issue(OP_SLT,  24'hFFFFFE, 24'h000001, 4'd4);
        issue(OP_CMP,  24'h000005, 24'h000005, 4'd5);
        issue(OP_NOR,  24'h0F0F0F, 24'h00FF00, 4'd6);
        issue(OP_NAND, 24'hFFFFFF, 24'hFFFFFF, 4'd7);
        issue(OP_OR,   24'h800000, 24'h000001, 4'd8);
        drain();

        // Stream of 8 ADDs with a 3-cycle consumer stall in the middle
        idx = 0;
        c   = 0;
        while (idx < 8 && c < 60) begin
            step(1'b1, OP_ADD, 24'($urandom), 24'($urandom), 4'(idx),
                 !(c >= 3 && c < 6), acc);
            if (acc) idx++;
            c++;
        end
        check_eq("stream_issued", 32'(idx), 32'(8));
        drain();

        // Reset while both stages are full and stalled
        step(1'b1, OP_SUB, 24'h7FFFFF, 24'hFFFFFF, 4'd9, 1'b0, acc);
        step(1'b1, OP_ADD, 24'h000010, 24'h000020, 4'd10, 1'b0, acc);
        step(1'b1, OP_ADD, 24'h000030, 24'h000040, 4'd11, 1'b0, acc);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        sb.delete();
        sticky_m  = 1'b0;
        hold_pend = 1'b0;
        check_reset_state();
        @(posedge clk);
        #1;
        drain();

        // Randomized traffic with random backpressure
        have_pend = 1'b0;
        p_op = '0; p_a = '0; p_b = '0; p_tag = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have_pend && ($urandom % 10) < 7) begin
                have_pend = 1'b1;
                p_op  = 3'($urandom);
                p_a   = rnd_operand();
                p_b   = rnd_operand();
                p_tag = 4'($urandom);
            end
            step(have_pend, p_op, p_a, p_b, p_tag, ($urandom % 10) < 7, acc);
            if (acc) have_pend = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
